// File: rtl/procyon_ifq_wb.sv
// procyon_ifq_wb
//   Instruction fetch queue for the core's ifq_alloc/ifq_fill interface.
//   Line-miss allocations are aligned to the icache line and queued in
//   order. Each queued line is fetched as a Wishbone classic incrementing
//   burst read. The full line is then returned with a one-cycle fill pulse.
//
// Ports
//   i_wb_clk, i_wb_rst        clock and synchronous active-high reset
//   i_alloc_en, i_alloc_addr  allocate a line fetch (any byte in the line)
//   o_full                    queue full, allocation ignored
//   o_fill_en/addr/data       one-cycle line fill (line-aligned address)
//   i_wb_ack, i_wb_data       Wishbone read response
//   o_wb_cyc/stb/we/cti/bte/sel/addr  Wishbone initiator controls
//
// Configuration
//   IFQ_MERGE_EN  when defined, an allocation whose line already sits in
//                 the queue (and is not popping this cycle) is dropped.

module procyon_ifq_wb #(
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_IC_LINE_SIZE  = 32,
  parameter int OPTN_IFQ_DEPTH     = 2,
  parameter int OPTN_WB_DATA_WIDTH = 32,
  parameter int OPTN_WB_ADDR_WIDTH = 32
) (
  input  logic                            i_wb_clk,
  input  logic                            i_wb_rst,
  input  logic                            i_alloc_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]      i_alloc_addr,
  output logic                            o_full,
  output logic                            o_fill_en,
  output logic [OPTN_ADDR_WIDTH-1:0]      o_fill_addr,
  output logic [OPTN_IC_LINE_SIZE*8-1:0]  o_fill_data,
  input  logic                            i_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_wb_data,
  output logic                            o_wb_cyc,
  output logic                            o_wb_stb,
  output logic                            o_wb_we,
  output logic [2:0]                      o_wb_cti,
  output logic [1:0]                      o_wb_bte,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0] o_wb_sel,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]   o_wb_addr
);

  localparam int WB_DATA_SIZE = OPTN_WB_DATA_WIDTH / 8;
  localparam int NUM_BEATS    = OPTN_IC_LINE_SIZE / WB_DATA_SIZE;
  localparam int BEAT_W       = $clog2(NUM_BEATS) + 1;
  localparam int IDX_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int PTR_W        = (OPTN_IFQ_DEPTH > 1) ? $clog2(OPTN_IFQ_DEPTH) : 1;
  localparam int CNT_W        = $clog2(OPTN_IFQ_DEPTH + 1);

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FILL
  } state_t;

  state_t state;
  state_t state_next;

  logic [OPTN_ADDR_WIDTH-1:0]    queue [OPTN_IFQ_DEPTH];
  logic [PTR_W-1:0]              head;
  logic [PTR_W-1:0]              tail;
  logic [CNT_W-1:0]              count;
  logic [OPTN_ADDR_WIDTH-1:0]    alloc_line;
  logic [OPTN_ADDR_WIDTH-1:0]    head_addr;
  logic [OPTN_WB_ADDR_WIDTH-1:0] head_wb_addr;
  logic                          push;
  logic                          pop;
  logic                          merge_hit;

  logic [BEAT_W-1:0]                                beat;
  logic                                             last_beat;
  logic [NUM_BEATS-1:0][OPTN_WB_DATA_WIDTH-1:0]     line_buf;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OPTN_IFQ_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign alloc_line = i_alloc_addr & ~OPTN_ADDR_WIDTH'(OPTN_IC_LINE_SIZE - 1);
  assign head_addr  = queue[head];
  assign o_full     = (count == CNT_W'(OPTN_IFQ_DEPTH));
  assign pop        = (state == FILL);
  assign push       = i_alloc_en & ~o_full & ~merge_hit;
  assign last_beat  = (beat == BEAT_W'(NUM_BEATS - 1));

  assign o_wb_we     = 1'b0;
  assign o_wb_bte    = 2'b00;
  assign o_fill_data = line_buf;

  // Wishbone byte address is the core address zero-extended or truncated
  generate
    if (OPTN_WB_ADDR_WIDTH > OPTN_ADDR_WIDTH) begin : g_addr_ext
      assign head_wb_addr = {{(OPTN_WB_ADDR_WIDTH-OPTN_ADDR_WIDTH){1'b0}}, head_addr};
    end else begin : g_addr_trunc
      assign head_wb_addr = head_addr[OPTN_WB_ADDR_WIDTH-1:0];
    end
  endgenerate

`ifdef IFQ_MERGE_EN
  // Per-entry valid bits let a new allocation be compared against every
  // queued line; the head is excluded in the cycle it pops.
  logic [OPTN_IFQ_DEPTH-1:0] valid;

  always_comb begin
    merge_hit = 1'b0;
    for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
      if (valid[i] && (queue[i] == alloc_line) && !(pop && (PTR_W'(i) == head)))
        merge_hit = 1'b1;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      valid <= '0;
    end else begin
      if (pop)  valid[head] <= 1'b0;
      if (push) valid[tail] <= 1'b1;
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  // Allocation FIFO; o_full comes from the registered count so a pop in
  // the same cycle never admits an allocation presented while full.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        queue[tail] <= alloc_line;
        tail        <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = BURST;
      BURST:   if (i_wb_ack && last_beat) state_next = FILL;
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus controls and fill outputs are registered; they change on the edge
  // that moves the FSM, so cyc rises one edge after a non-empty queue is
  // seen and drops on the edge that takes the final ack.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_cti    <= 3'b000;
      o_wb_sel    <= '0;
      o_wb_addr   <= '0;
      beat        <= '0;
      o_fill_en   <= 1'b0;
      o_fill_addr <= '0;
      line_buf    <= '0;
    end else begin
      o_fill_en <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            o_wb_addr <= head_wb_addr;
            beat      <= '0;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_sel  <= '1;
            o_wb_cti  <= (NUM_BEATS == 1) ? CTI_END : CTI_INCR;
          end
        end
        BURST: begin
          if (i_wb_ack) begin
            line_buf[beat[IDX_W-1:0]] <= i_wb_data;
            beat      <= beat + BEAT_W'(1);
            o_wb_addr <= o_wb_addr + OPTN_WB_ADDR_WIDTH'(WB_DATA_SIZE);
            if (last_beat) begin
              o_wb_cyc    <= 1'b0;
              o_wb_stb    <= 1'b0;
              o_wb_sel    <= '0;
              o_wb_cti    <= 3'b000;
              o_fill_en   <= 1'b1;
              o_fill_addr <= head_addr;
            end else if (beat == BEAT_W'(NUM_BEATS - 2)) begin
              o_wb_cti <= CTI_END;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
